bilinear_downscale_scheduler: RTL and testbench
===============================================

# bilinear_downscale_scheduler

Sequencing controller for the sequential bilinear downscale path. It arbitrates the single-port source BRAM between the JTAG configuration writer and the scaler. For every destination pixel it generates the fixed-point source coordinates and fetches the four neighbour pixels. It then hands the quad and its weights to the interpolator over a valid/ready handshake and writes the returned pixel into the destination BRAM. It sits between the top level's `cfg_*`/`start_req` ports and the interpolator/memories, and replaces the ad-hoc sequencing inside the top.

## Interface
Parameters:
- `SRC_W`, 32, source width in pixels
- `SRC_H`, 32, source height in pixels
- `DST_W`, 16, destination width (≥2)
- `DST_H`, 16, destination height (≥2)
- `FRAC`, 8, fractional bits of coordinates and weights

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_we`  in  1  configuration write strobe
- `cfg_addr`  in  16  source write address
- `cfg_data`  in  8  source write data
- `start_req`  in  1  start request (level sampled each cycle)
- `busy`  out  1  high from accepted start until `done` is set
- `done`  out  1  set after the last pixel is written; held until the next accepted start or reset
- `cfg_err`  out  1  sticky: `cfg_we` arrived while busy
- `src_we`, `src_addr[15:0]`, `src_wdata[7:0]`  out  source BRAM port
- `src_rdata`  in  8  source read data, valid 1 cycle after address
- `ip_valid`  out  1  operands valid
- `ip_ready`  in  1  interpolator accepts operands
- `ip_a`, `ip_b`, `ip_c`, `ip_d`  out  8 each  pixels (yl,xl), (yl,xh), (yh,xl), (yh,xh)
- `ip_xw`, `ip_yw`  out  FRAC each  fractional weights
- `ip_res_valid`  in  1  result strobe
- `ip_res`  in  8  interpolated pixel
- `dst_we`, `dst_addr[15:0]`, `dst_wdata[7:0]`  out  destination BRAM port

## Operation
- Steps are constants. `STEP_X = ((SRC_W-1)<<FRAC)/(DST_W-1)` and the analogous `STEP_Y` use truncating division. Defaults give 529 for both.
- Coordinates are accumulated, not multiplied. `xs` is cleared at each row start and incremented by `STEP_X` per column. `ys` is incremented by `STEP_Y` per row.
- Derived values:
  - `xl = xs>>FRAC` and `xw = xs[FRAC-1:0]`.
  - `xh = xl+1` if `xw≠0`, else `xl`; clamped to `SRC_W-1`.
  - `yl`, `yw`, `yh` are derived the same way with `SRC_H-1` as the clamp.
- Source address is `y*SRC_W + x`. Destination address is `i*DST_W + j`, row-major.
- Arbitration:
  - In IDLE/DONE, `cfg_we` drives the source port directly: `src_we=cfg_we`, `src_addr=cfg_addr`, `src_wdata=cfg_data`.
  - While busy, `src_we=0`. Any `cfg_we` is dropped and sets `cfg_err`.
- FSM states: IDLE, F0, F1, F2, F3, F4, ISSUE, WAIT, WRITE, DONE.
  - IDLE/DONE + `start_req` → F0. On entry, clear counters, `done` and `cfg_err`; set `busy`.
  - F0 drives address A. F1 drives B and captures A. F2 drives C and captures B. F3 drives D and captures C. F4 captures D. F4 → ISSUE.
  - ISSUE: `ip_valid=1`. Operands and weights are held stable until `ip_valid && ip_ready`, then → WAIT.
  - WAIT: on `ip_res_valid`, latch `ip_res` and go → WRITE. There is no timeout.
  - WRITE: `dst_we=1` for one cycle, then advance `j`/`i`. If the pixel was (DST_H-1, DST_W-1), go → DONE (`busy=0`, `done=1`); otherwise go → F0.
- `start_req` while busy is ignored.
- `ip_res_valid` outside WAIT is ignored.

## Timing
- Reset values: every output is 0; state is IDLE; all counters and accumulators are 0.
- Reset mid-operation aborts within 1 cycle. No further `dst_we` is issued after `rst`.
- The start is accepted on the cycle `start_req` is sampled; F0 follows in the next cycle.
- Per-pixel cost is 5 (fetch) + 1 (issue, with `ip_ready=1`) + L (interpolator latency, ≥1) + 1 (write).
- A full frame takes `DST_W*DST_H*(7+L)` cycles from F0 to DONE.
- `dst_we` is asserted exactly `DST_W*DST_H` times per frame and is never asserted twice for the same address.
- `src_rdata` is sampled exactly 1 cycle after its address is driven.

## Test plan
- Reset, then check outputs: all outputs are 0 and `busy=0`. Write 1024 configuration bytes with `(i*4+j*2)&255` → `src_we` mirrors `cfg_we` with matching address and data.
- Start with an L=2 interpolator model and `ip_ready=1`:
  - Pixel (0,0) reads addresses 0,0,0,0 with xw=yw=0.
  - Pixel (0,1) reads 2,3,2,3 with xw=17, yw=0.
  - Pixel (15,15) reads 990,991,1022,1023 with xw=yw=255 and `dst_addr=255`.
  - `done` rises at cycle 256*9 after F0, with 256 `dst_we` pulses in total.
- Hold `ip_ready=0` for 3 cycles in ISSUE → `ip_valid` stays high and all `ip_*` outputs are unchanged; the handshake completes on the 4th cycle.
- Pulse `cfg_we` at address 5 while busy → no `src_we`, `cfg_err=1` until the next start. A reference model using Q8 weights matches `dst_wdata` within ±1.
- Assert `rst` in the middle of pixel 40 → the next cycle is IDLE with all outputs 0. A fresh start rewrites from `dst_addr=0`.
- Pulse `start_req` while busy, and pulse `ip_res_valid` during F2 → there is no restart and the stray result is ignored.

Source files
------------

// File: rtl/bilinear_downscale_scheduler.sv
`timescale 1ns/1ps
// Purpose: sequences one bilinear downscale frame: shares the source BRAM with the
//          config writer, fetches four neighbours per destination pixel, hands them
//          to the interpolator and writes the result to the destination BRAM.
// Latency: 5 fetch + 1 issue + interpolator latency + 1 write cycles per pixel.
// Backpressure: operands are held in ISSUE until ip_ready; no timeout in WAIT.
// Ports: clk/rst; cfg_we/cfg_addr/cfg_data + start_req in; busy/done/cfg_err status;
//        src_* source BRAM port; ip_* interpolator handshake; dst_* destination port.
module bilinear_downscale_scheduler #(
  parameter int SRC_W = 32,
  parameter int SRC_H = 32,
  parameter int DST_W = 16,
  parameter int DST_H = 16,
  parameter int FRAC  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [15:0]     cfg_addr,
  input  logic [7:0]      cfg_data,
  input  logic            start_req,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
  output logic            src_we,
  output logic [15:0]     src_addr,
  output logic [7:0]      src_wdata,
  input  logic [7:0]      src_rdata,
  output logic            ip_valid,
  input  logic            ip_ready,
  output logic [7:0]      ip_a,
  output logic [7:0]      ip_b,
  output logic [7:0]      ip_c,
  output logic [7:0]      ip_d,
  output logic [FRAC-1:0] ip_xw,
  output logic [FRAC-1:0] ip_yw,
  input  logic            ip_res_valid,
  input  logic [7:0]      ip_res,
  output logic            dst_we,
  output logic [15:0]     dst_addr,
  output logic [7:0]      dst_wdata
);

  localparam int CW     = 16 + FRAC;
  localparam int STEP_X = ((SRC_W - 1) << FRAC) / (DST_W - 1);
  localparam int STEP_Y = ((SRC_H - 1) << FRAC) / (DST_H - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_F4, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]   xs, ys;
  logic [15:0]     col, row;
  logic [7:0]      pa, pb, pc, pd, res_q;
  logic            err_q;
  logic [15:0]     xl, yl, xh, yh;
  logic [FRAC-1:0] xw, yw;
  logic [15:0]     fetch_x, fetch_y;
  logic            last_px;

  assign xl = xs[CW-1:FRAC];
  assign yl = ys[CW-1:FRAC];
  assign xw = xs[FRAC-1:0];
  assign yw = ys[FRAC-1:0];
  assign last_px = (row == 16'(DST_H - 1)) && (col == 16'(DST_W - 1));

  // Upper neighbour only steps when there is a fractional part, and never past the edge.
  always_comb begin
    xh = xl;
    yh = yl;
    if (xw != '0) xh = xl + 16'd1;
    if (yw != '0) yh = yl + 16'd1;
    if (xh > 16'(SRC_W - 1)) xh = 16'(SRC_W - 1);
    if (yh > 16'(SRC_H - 1)) yh = 16'(SRC_H - 1);
  end

  // F0..F3 put A, B, C, D on the address bus in that order.
  always_comb begin
    fetch_x = xl;
    fetch_y = yl;
    case (state)
      S_F1:    begin fetch_x = xh; fetch_y = yl; end
      S_F2:    begin fetch_x = xl; fetch_y = yh; end
      S_F3:    begin fetch_x = xh; fetch_y = yh; end
      default: begin fetch_x = xl; fetch_y = yl; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    ip_valid  = 1'b0;
    dst_we    = 1'b0;
    src_we    = 1'b0;
    src_addr  = fetch_y * 16'(SRC_W) + fetch_x;
    src_wdata = 8'd0;
    case (state)
      S_IDLE, S_DONE: begin
        busy      = 1'b0;
        done      = (state == S_DONE);
        // Outside a frame the config writer owns the source port outright.
        src_we    = cfg_we;
        src_addr  = cfg_addr;
        src_wdata = cfg_data;
        if (start_req) state_nxt = S_F0;
      end
      S_F0:    state_nxt = S_F1;
      S_F1:    state_nxt = S_F2;
      S_F2:    state_nxt = S_F3;
      S_F3:    state_nxt = S_F4;
      S_F4:    state_nxt = S_ISSUE;
      S_ISSUE: begin
        ip_valid = 1'b1;
        if (ip_ready) state_nxt = S_WAIT;
      end
      S_WAIT:  if (ip_res_valid) state_nxt = S_WRITE;
      S_WRITE: begin
        dst_we    = 1'b1;
        state_nxt = last_px ? S_DONE : S_F0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xs    <= '0;
      ys    <= '0;
      col   <= '0;
      row   <= '0;
      pa    <= '0;
      pb    <= '0;
      pc    <= '0;
      pd    <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_req) begin
            xs    <= '0;
            ys    <= '0;
            col   <= '0;
            row   <= '0;
            err_q <= 1'b0;
          end
        end
        // BRAM data lands one cycle after its address, hence the one-state skew.
        S_F1: pa <= src_rdata;
        S_F2: pb <= src_rdata;
        S_F3: pc <= src_rdata;
        S_F4: pd <= src_rdata;
        S_WAIT: if (ip_res_valid) res_q <= ip_res;
        S_WRITE: begin
          if (col == 16'(DST_W - 1)) begin
            col <= '0;
            xs  <= '0;
            row <= row + 16'd1;
            ys  <= ys + CW'(STEP_Y);
          end else begin
            col <= col + 16'd1;
            xs  <= xs + CW'(STEP_X);
          end
        end
        default: ;
      endcase
      if (busy && cfg_we) err_q <= 1'b1;
    end
  end

  assign cfg_err   = err_q;
  assign ip_a      = pa;
  assign ip_b      = pb;
  assign ip_c      = pc;
  assign ip_d      = pd;
  assign ip_xw     = xw;
  assign ip_yw     = yw;
  assign dst_addr  = row * 16'(DST_W) + col;
  assign dst_wdata = res_q;

endmodule

// File: tb/tb_bilinear_downscale_scheduler.sv
`timescale 1ns/1ps
module tb_bilinear_downscale_scheduler;

  localparam int SRC_W  = 32;
  localparam int SRC_H  = 32;
  localparam int DST_W  = 16;
  localparam int DST_H  = 16;
  localparam int FRAC   = 8;
  localparam int LAT    = 2;
  localparam int NPIX   = DST_W * DST_H;
  localparam int STEP_X = ((SRC_W - 1) << FRAC) / (DST_W - 1);
  localparam int STEP_Y = ((SRC_H - 1) << FRAC) / (DST_H - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        start_req = 1'b0;
  logic        busy, done, cfg_err, src_we;
  logic [15:0] src_addr;
  logic [7:0]  src_wdata;
  logic [7:0]  src_rdata = '0;
  logic        ip_valid;
  logic        ip_ready = 1'b1;
  logic [7:0]  ip_a, ip_b, ip_c, ip_d;
  logic [7:0]  ip_xw, ip_yw;
  logic        ip_res_valid = 1'b0;
  logic [7:0]  ip_res = '0;
  logic        dst_we;
  logic [15:0] dst_addr;
  logic [7:0]  dst_wdata;

  always #5 clk = ~clk;

  bilinear_downscale_scheduler #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H), .FRAC(FRAC)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start_req(start_req), .busy(busy), .done(done), .cfg_err(cfg_err),
    .src_we(src_we), .src_addr(src_addr), .src_wdata(src_wdata), .src_rdata(src_rdata),
    .ip_valid(ip_valid), .ip_ready(ip_ready), .ip_a(ip_a), .ip_b(ip_b), .ip_c(ip_c),
    .ip_d(ip_d), .ip_xw(ip_xw), .ip_yw(ip_yw), .ip_res_valid(ip_res_valid),
    .ip_res(ip_res), .dst_we(dst_we), .dst_addr(dst_addr), .dst_wdata(dst_wdata)
  );

  wire [47:0]  ops  = {ip_a, ip_b, ip_c, ip_d, ip_xw, ip_yw};
  wire [101:0] outs = {busy, done, cfg_err, src_we, src_addr, src_wdata, ip_valid,
                       ip_a, ip_b, ip_c, ip_d, ip_xw, ip_yw, dst_we, dst_addr, dst_wdata};

  // Source BRAM: registered read, one cycle latency.
  logic [7:0] bram [0:65535];
  logic [7:0] ref_mem [0:SRC_W*SRC_H-1];
  always @(posedge clk) begin
    if (src_we) bram[src_addr] <= src_wdata;
    src_rdata <= bram[src_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] interp(input logic [47:0] o);
    int a, b, c, d, xw, yw, top, bot;
    a = int'(o[47:40]); b = int'(o[39:32]); c = int'(o[31:24]); d = int'(o[23:16]);
    xw = int'(o[15:8]); yw = int'(o[7:0]);
    top = a * (256 - xw) + b * xw;
    bot = c * (256 - xw) + d * xw;
    return 8'((top * (256 - yw) + bot * yw) >> 16);
  endfunction

  logic [47:0] exp_op [$];
  logic [23:0] exp_wr [$];

  task automatic push_frame();
    int xs, ys, xl, yl, xh, yh, xw, yw;
    logic [47:0] o;
    for (int i = 0; i < DST_H; i++) begin
      for (int j = 0; j < DST_W; j++) begin
        xs = j * STEP_X; ys = i * STEP_Y;
        xl = xs >> FRAC; xw = xs % (1 << FRAC);
        yl = ys >> FRAC; yw = ys % (1 << FRAC);
        xh = (xw != 0) ? xl + 1 : xl; if (xh > SRC_W - 1) xh = SRC_W - 1;
        yh = (yw != 0) ? yl + 1 : yl; if (yh > SRC_H - 1) yh = SRC_H - 1;
        o = {ref_mem[yl*SRC_W+xl], ref_mem[yl*SRC_W+xh], ref_mem[yh*SRC_W+xl],
             ref_mem[yh*SRC_W+xh], 8'(xw), 8'(yw)};
        exp_op.push_back(o);
        exp_wr.push_back({16'(i * DST_W + j), interp(o)});
      end
    end
  endtask

  // Interpolator model (latency LAT) plus destination-write scoreboard.
  int          wr_count = 0;
  int          stall_at = -1;
  int          stray_at = -1;
  int          pend = 0, stall_left = 0, phase = 0;
  bit          stall_post = 0, stall_used = 0, stray_used = 0;
  logic [47:0] snap, e_op;
  logic [23:0] e_wr;
  logic [7:0]  res_hold;

  always @(negedge clk) begin
    if (rst) begin
      pend = 0; ip_res_valid = 0; ip_ready = 1; stall_left = 0; stall_post = 0; phase = 0;
    end else begin
      if (dst_we) begin
        wr_count++;
        phase = 0;
        if (exp_wr.size() == 0) chk("dst_unexpected_we", dst_we, 0);
        else begin
          e_wr = exp_wr.pop_front();
          chk("dst_addr", dst_addr, e_wr[23:8]);
          chk("dst_wdata", dst_wdata, e_wr[7:0]);
        end
      end else phase++;
      ip_res_valid = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin ip_res_valid = 1; ip_res = res_hold; end
      end
      // Stray result during F2 (phase 3 counts WRITE as 0).
      if (!stray_used && wr_count == stray_at && phase == 3) begin
        stray_used = 1; ip_res_valid = 1; ip_res = 8'hEE;
      end
      ip_ready = 1;
      if (ip_valid && !stall_used && wr_count == stall_at) begin
        stall_used = 1; stall_left = 3; snap = ops;
      end
      if (stall_left > 0) begin
        if (stall_left < 3) begin
          chk("stall_ip_valid", ip_valid, 1);
          chk("stall_ops_stable", ops, snap);
        end
        ip_ready = 0;
        stall_left--;
        stall_post = (stall_left == 0);
      end else if (stall_post) begin
        chk("stall_release_valid", ip_valid, 1);
        chk("stall_release_ops", ops, snap);
        stall_post = 0;
      end
      if (ip_valid && ip_ready) begin
        if (exp_op.size() == 0) chk("ip_unexpected_valid", ip_valid, 0);
        else begin
          e_op = exp_op.pop_front();
          chk("ip_operands", ops, e_op);
        end
        res_hold = interp(ops);
        pend = LAT;
      end
    end
  end

  task automatic start_frame(output time t0);
    push_frame();
    start_req = 1;
    @(negedge clk);
    start_req = 0;
    t0 = $time;
    chk("busy_in_f0", busy, 1);
    chk("done_cleared", done, 0);
  endtask

  task automatic wait_done(input time t0, output int cyc);
    int k = 0;
    while (!done && k < 4000) begin @(negedge clk); k++; end
    if (!done) chk("done_timeout", done, 1);
    cyc = int'(($time - t0) / 10);
  endtask

  task automatic wait_writes(input int target);
    int k = 0;
    while (wr_count < target && k < 4000) begin @(negedge clk); k++; end
    if (wr_count < target) chk("wait_writes_timeout", wr_count, target);
  endtask

  initial begin
    time t0;
    int  cyc, base, d;
    for (int a = 0; a < 65536; a++) bram[a] = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_outputs", outs, 0);

    // Load the source image through the shared port.
    for (int a = 0; a < SRC_W * SRC_H; a++) begin
      d = ((a / SRC_W) * 4 + (a % SRC_W) * 2) & 255;
      ref_mem[a] = 8'(d);
      cfg_we = 1; cfg_addr = 16'(a); cfg_data = 8'(d);
      #1;
      chk("cfg_mirror", {src_we, src_addr, src_wdata}, {1'b1, 16'(a), 8'(d)});
      @(negedge clk);
    end
    cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    #1 chk("cfg_idle_src_we", src_we, 0);
    @(negedge clk);

    // Frame 1: clean run, ip_ready always high.
    base = wr_count;
    start_frame(t0);
    wait_done(t0, cyc);
    chk("frame1_cycles", cyc, NPIX * (7 + LAT));
    chk("frame1_writes", wr_count - base, NPIX);
    chk("frame1_queue_empty", exp_wr.size(), 0);
    chk("frame1_busy_low", busy, 0);
    repeat (3) @(negedge clk);
    chk("done_held", done, 1);

    // Frame 2: stall, busy config write, start while busy, stray result.
    base = wr_count;
    stall_at = base + 3;
    stray_at = base + 10;
    start_frame(t0);
    wait_writes(base + 6);
    cfg_we = 1; cfg_addr = 16'd5; cfg_data = 8'h99;
    #1 chk("busy_blocks_src_we", src_we, 0);
    @(negedge clk);
    cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    chk("cfg_err_set", cfg_err, 1);
    start_req = 1;
    @(negedge clk);
    start_req = 0;
    chk("busy_after_restart_req", busy, 1);
    wait_done(t0, cyc);
    chk("frame2_cycles", cyc, NPIX * (7 + LAT) + 3);
    chk("frame2_writes", wr_count - base, NPIX);
    chk("frame2_queue_empty", exp_wr.size(), 0);
    chk("cfg_err_sticky", cfg_err, 1);
    @(negedge clk);

    // Frame 3: abort with reset in the middle of pixel 40.
    base = wr_count;
    start_frame(t0);
    chk("cfg_err_cleared", cfg_err, 0);
    wait_writes(base + 40);
    repeat (2) @(negedge clk);
    rst = 1;
    exp_op.delete();
    exp_wr.delete();
    @(negedge clk);
    chk("abort_outputs", outs, 0);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("abort_stays_idle", outs, 0);
    chk("abort_write_count", wr_count - base, 40);

    // Frame 4: fresh start after the abort.
    base = wr_count;
    start_frame(t0);
    wait_done(t0, cyc);
    chk("frame4_cycles", cyc, NPIX * (7 + LAT));
    chk("frame4_writes", wr_count - base, NPIX);
    chk("frame4_queue_empty", exp_wr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
